ps2_calc_top: RTL and testbench

- Four-digit decimal add/subtract calculator driven by a PS/2 keyboard; the result is shown on a multiplexed 7-segment display.
- Contains a PS/2 frame receiver, a scan-code decoder, the calculator FSM and BCD digit registers (dig1, dig10, dig100, dig1000), plus a display scanner.
- Top level of the board design; only pins are exposed.

---
 rtl/ps2_calc_pkg.sv | 58 +++++
 rtl/ps2_calc_if.sv | 9 +
 rtl/ps2_calc_rx.sv | 95 +++++++++
 rtl/ps2_calc_top.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_calc_top.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_calc_pkg.sv
// Shared scan codes, FSM/op enums, 7-segment patterns and the arithmetic helpers for ps2_calc_top.
// Pure definitions: no latency, no flow control.
package ps2_calc_pkg;

    typedef enum logic [1:0] {ENTRY_A, OP_WAIT, ENTRY_B, RESULT} calc_state_e;
    typedef enum logic {OP_ADD, OP_SUB} calc_op_e;

    // Element [i] is the make code of digit i.
    localparam logic [9:0][7:0] SC_DIGIT = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                            8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
    localparam logic [9:0][7:0] SC_KPAD  = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                            8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};
    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_PLUS    = 8'h79;
    localparam logic [7:0] SC_MINUS   = 8'h7B;
    localparam logic [7:0] SC_EQUALS  = 8'h55;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_CLEAR   = 8'h76;

    // Active-low segments, bit 7 = DP, bits [6:0] = g..a.
    localparam logic [9:0][7:0] SEG_DIGIT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                             8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Returns {valid, value}; both the main row and the keypad map to 0..9.
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 0; i < 10; i++) begin
            if (code == SC_DIGIT[i] || code == SC_KPAD[i]) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    // Operands never exceed 9999, so nine subtraction steps cover every case.
    function automatic logic [13:0] mod1000(input logic [13:0] v);
        logic [13:0] m;
        m = v;
        for (int i = 0; i < 9; i++) begin
            if (m >= 14'd1000) m = m - 14'd1000;
        end
        return m;
    endfunction

    function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
        logic [29:0] s;
        s = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (s[14+4*k +: 4] >= 4'd5) s[14+4*k +: 4] = s[14+4*k +: 4] + 4'd3;
            end
            s = s << 1;
        end
        return s[29:14];
    endfunction

endpackage

// File: rtl/ps2_calc_if.sv
// Received-byte channel from the PS/2 receiver to the calculator: one-cycle key_vld strobe with key_code.
// No backpressure; the consumer must accept every strobe.
interface ps2_calc_if;
    logic       key_vld;
    logic [7:0] key_code;

    modport master (output key_vld, key_code);
    modport slave  (input  key_vld, key_code);
endinterface

// File: rtl/ps2_calc_rx.sv
// PS/2 receiver: 2-FF sync, falling-edge detect, 11-bit frame shifter; strobe ~2 cycles after the stop-bit fall.
// No backpressure. Build with PS2_PARITY_CHECK_EN to drop frames whose odd parity is wrong.
module ps2_rx #(
    parameter logic [15:0] IDLE_TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    ps2_calc_if.master key
);

    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_prev;
    logic        fall;
    logic        ps2_dat;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        start_bad;
    logic [15:0] idle_cnt;
    logic        par_ok;
    logic        key_vld;
    logic [7:0]  key_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign ps2_dat = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_ok <= 1'b1;
        end else if (fall && bit_cnt == 4'd9) begin
            par_ok <= ^{shreg, ps2_dat};
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    // A bad start bit still consumes all eleven bits so framing stays aligned;
    // the idle timeout recovers from a stray edge mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            start_bad <= 1'b0;
            idle_cnt  <= 16'd0;
            key_vld   <= 1'b0;
            key_code  <= 8'd0;
        end else begin
            key_vld <= 1'b0;
            if (fall) begin
                idle_cnt <= 16'd0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (ps2_dat && !start_bad && par_ok) begin
                        key_vld  <= 1'b1;
                        key_code <= shreg;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (bit_cnt == 4'd0) begin
                    start_bad <= ps2_dat;
                end else if (bit_cnt <= 4'd8) begin
                    shreg <= {ps2_dat, shreg[7:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == IDLE_TIMEOUT) begin
                    bit_cnt  <= 4'd0;
                    idle_cnt <= 16'd0;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end
        end
    end

    assign key.key_vld  = key_vld;
    assign key.key_code = key_code;

endmodule

// File: rtl/ps2_calc_top.sv
// PS/2 four-digit add/subtract calculator with multiplexed 7-segment display; digits settle 2 cycles after key_vld.
// No backpressure: every key strobe is consumed. Optional PS2_PARITY_CHECK_EN enables receiver parity check.
module ps2_calc_top #(
    parameter logic [15:0] REFRESH_DIV = 16'd1000,
    parameter int          MAX_DIGITS  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] led7_seg_o,
    output logic [7:0] led7_an_o
);
    import ps2_calc_pkg::*;

    localparam logic [2:0] DIG_LIM = 3'(MAX_DIGITS);

    ps2_calc_if key_if ();

    ps2_rx u_rx (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .ps2_clk  (ps2_clk_i),
        .ps2_data (ps2_data_i),
        .key      (key_if.master)
    );

    logic       brk;
    logic       live;
    logic [4:0] dig_dec;
    logic [3:0] key_digit;
    logic       ev_digit, ev_op, ev_eq, ev_clr;
    calc_op_e   key_op;

    // The byte after a break code belongs to a key release and is swallowed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            brk <= 1'b0;
        end else if (key_if.key_vld) begin
            brk <= !brk && (key_if.key_code == SC_BREAK);
        end
    end

    assign live = key_if.key_vld && !brk && (key_if.key_code != SC_BREAK);

    always_comb begin
        dig_dec   = digit_of(key_if.key_code);
        ev_digit  = live && dig_dec[4];
        key_digit = dig_dec[3:0];
        ev_op     = 1'b0;
        ev_eq     = 1'b0;
        ev_clr    = 1'b0;
        key_op    = OP_ADD;
        case (key_if.key_code)
            SC_PLUS:             ev_op = live;
            SC_MINUS:            begin ev_op = live; key_op = OP_SUB; end
            SC_EQUALS, SC_ENTER: ev_eq = live;
            SC_CLEAR:            ev_clr = live;
            default:             ;
        endcase
    end

    calc_state_e state;
    calc_op_e    op;
    logic [13:0] a, b, r;
    logic [2:0]  na, nb;
    logic        r_neg, r_ovf;
    logic [13:0] dig_ext, a_acc, b_acc;
    logic [14:0] sum;
    logic [13:0] mag;
    logic [13:0] res_val;
    logic        res_neg, res_ovf;

    assign dig_ext = {10'd0, key_digit};
    assign a_acc   = a * 14'd10 + dig_ext;
    assign b_acc   = b * 14'd10 + dig_ext;

    // Negative results keep only the magnitude's low three digits; chaining reuses that shown value.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        mag     = (a >= b) ? (a - b) : (b - a);
        res_val = 14'd0;
        res_neg = 1'b0;
        res_ovf = 1'b0;
        if (op == OP_ADD) begin
            res_ovf = sum > 15'd9999;
            res_val = res_ovf ? 14'(sum - 15'd10000) : sum[13:0];
        end else begin
            res_neg = a < b;
            res_ovf = res_neg && (mag > 14'd999);
            res_val = res_neg ? mod1000(mag) : mag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ENTRY_A;
            op    <= OP_ADD;
            a     <= 14'd0;
            b     <= 14'd0;
            r     <= 14'd0;
            na    <= 3'd0;
            nb    <= 3'd0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
        end else if (ev_clr) begin
            state <= ENTRY_A;
            a     <= 14'd0;
            b     <= 14'd0;
            r     <= 14'd0;
            na    <= 3'd0;
            nb    <= 3'd0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
        end else if (ev_digit) begin
            case (state)
                ENTRY_A: if (na < DIG_LIM) begin a <= a_acc; na <= na + 3'd1; end
                OP_WAIT: begin b <= dig_ext; nb <= 3'd1; state <= ENTRY_B; end
                ENTRY_B: if (nb < DIG_LIM) begin b <= b_acc; nb <= nb + 3'd1; end
                default: begin a <= dig_ext; na <= 3'd1; state <= ENTRY_A; end
            endcase
        end else if (ev_op) begin
            op    <= key_op;
            state <= OP_WAIT;
            if (state == ENTRY_B) begin
                r     <= res_val;
                r_neg <= res_neg;
                r_ovf <= res_ovf;
                a     <= res_val;
            end else if (state == RESULT) begin
                a <= r;
            end
        end else if (ev_eq && state == ENTRY_B) begin
            r     <= res_val;
            r_neg <= res_neg;
            r_ovf <= res_ovf;
            state <= RESULT;
        end
    end

    logic [13:0] disp_val;
    logic [3:0]  dig1, dig10, dig100, dig1000;
    logic        neg_q, ovf_q;

    always_comb begin
        case (state)
            ENTRY_B: disp_val = b;
            RESULT:  disp_val = r;
            default: disp_val = a;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {dig1000, dig100, dig10, dig1} <= 16'd0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            {dig1000, dig100, dig10, dig1} <= bin2bcd(disp_val);
            neg_q <= (state == RESULT) && r_neg;
            ovf_q <= (state == RESULT) && r_ovf;
        end
    end

    logic [15:0] refresh_cnt;
    logic [1:0]  scan_idx;
    logic [3:0]  cur;
    logic        blank;
    logic [7:0]  seg_nxt, an_nxt;

    // Leading zeros blank; a negative result never has a thousands digit, so '-' never collides.
    always_comb begin
        cur   = dig1;
        blank = 1'b0;
        case (scan_idx)
            2'd1:    begin cur = dig10;   blank = ({dig1000, dig100, dig10} == 12'd0); end
            2'd2:    begin cur = dig100;  blank = ({dig1000, dig100} == 8'd0); end
            2'd3:    begin cur = dig1000; blank = (dig1000 == 4'd0); end
            default: ;
        endcase
        seg_nxt = blank ? SEG_BLANK : SEG_DIGIT[cur];
        if (neg_q && scan_idx == 2'd3) seg_nxt = SEG_MINUS;
        if (ovf_q && scan_idx == 2'd0) seg_nxt[7] = 1'b0;
        an_nxt = {4'hF, ~(4'b0001 << scan_idx)};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refresh_cnt <= 16'd0;
            scan_idx    <= 2'd0;
            led7_seg_o  <= 8'hC0;
            led7_an_o   <= 8'hFE;
        end else begin
            if (refresh_cnt == REFRESH_DIV - 16'd1) begin
                refresh_cnt <= 16'd0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
            led7_seg_o <= seg_nxt;
            led7_an_o  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_calc_top.sv
// Randomized PS/2 keystrokes against a behavioural calculator model; checks every scanned digit after each key.
module tb_ps2_calc_top;

    localparam logic [15:0] RDIV = 16'd8;
    localparam int S_A = 0, S_OW = 1, S_B = 2, S_R = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] seg, an;
    int         total = 0;
    int         bad = 0;

    ps2_calc_if stim ();

    ps2_calc_top #(.REFRESH_DIV(RDIV), .MAX_DIGITS(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .led7_seg_o (seg),
        .led7_an_o  (an)
    );

    always #5 clk = ~clk;

    logic [7:0] pat   [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kcode [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] junk  [5]  = '{8'h1C, 8'h32, 8'h21, 8'h29, 8'h66};

    // Calculator model: plain integers for operands, typed-digit counts and result flags.
    int ma, mb, mr, mna, mnb, mst;
    bit msub, mneg, movf, mbrk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int key_digit(input logic [7:0] c);
        for (int i = 0; i < 10; i++) if (c == dcode[i] || c == kcode[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        ma = 0; mb = 0; mr = 0; mna = 0; mnb = 0; mneg = 0; movf = 0; mst = S_A;
    endtask

    task automatic model_calc();
        if (!msub) begin
            movf = (ma + mb) > 9999; mneg = 0; mr = (ma + mb) % 10000;
        end else if (ma >= mb) begin
            mr = ma - mb; mneg = 0; movf = 0;
        end else begin
            mneg = 1; movf = (mb - ma) > 999; mr = (mb - ma) % 1000;
        end
    endtask

    task automatic model_key(input logic [7:0] c);
        int d;
        if (mbrk) begin mbrk = 0; return; end
        if (c == 8'hF0) begin mbrk = 1; return; end
        d = key_digit(c);
        if (c == 8'h76) begin
            model_clear();
        end else if (d >= 0) begin
            case (mst)
                S_A:  if (mna < 4) begin ma = ma * 10 + d; mna++; end
                S_OW: begin mb = d; mnb = 1; mst = S_B; end
                S_B:  if (mnb < 4) begin mb = mb * 10 + d; mnb++; end
                default: begin ma = d; mna = 1; mst = S_A; end
            endcase
        end else if (c == 8'h79 || c == 8'h7B) begin
            if (mst == S_B) begin model_calc(); ma = mr; end
            else if (mst == S_R) ma = mr;
            msub = (c == 8'h7B);
            mst = S_OW;
        end else if ((c == 8'h55 || c == 8'h5A) && mst == S_B) begin
            model_calc();
            mst = S_R;
        end
    endtask

    function automatic logic [31:0] model_disp();
        int val, p;
        bit neg, ovf;
        logic [7:0] s [4];
        val = (mst == S_R) ? mr : (mst == S_B) ? mb : ma;
        neg = (mst == S_R) && mneg;
        ovf = (mst == S_R) && movf;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            s[k] = (k > 0 && val < p) ? 8'hFF : pat[(val / p) % 10];
            p = p * 10;
        end
        if (neg) s[3] = 8'hBF;
        if (ovf) s[0][7] = 1'b0;
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic ps2_frame(input logic [7:0] code, input bit bad_start, input bit bad_stop, input bit bad_par);
        logic [10:0] bits;
        int hp;
        stim.key_code = code;
        stim.key_vld  = 1'b1;
        hp = $urandom_range(3, 8);
        bits = {~bad_stop, (~^stim.key_code) ^ bad_par, stim.key_code, bad_start};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); ps2_data = bits[i];
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        stim.key_vld = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        logic [7:0] slot [4];
        logic [4:0] scan;
        scan = 5'd0;
        for (int i = 0; i < 4; i++) slot[i] = 8'h00;
        for (int i = 0; i < 4 * RDIV + 8; i++) begin
            @(negedge clk);
            case (an)
                8'hFE: begin slot[0] = seg; scan[0] = 1'b1; end
                8'hFD: begin slot[1] = seg; scan[1] = 1'b1; end
                8'hFB: begin slot[2] = seg; scan[2] = 1'b1; end
                8'hF7: begin slot[3] = seg; scan[3] = 1'b1; end
                default: scan[4] = 1'b1;
            endcase
        end
        chk({tag, "_scan"}, 32'(scan), 32'h0F);
        chk(tag, {slot[3], slot[2], slot[1], slot[0]}, model_disp());
    endtask

    task automatic key(input logic [7:0] c);
        ps2_frame(c, 1'b0, 1'b0, 1'b0);
        model_key(c);
        check_disp($sformatf("key%02h", c));
    endtask

    logic [7:0] dir_keys [$] = '{8'h46, 8'h46, 8'h16, 8'h7B, 8'h16, 8'h1E, 8'h26, 8'h55,
                                 8'h76,
                                 8'h46, 8'h46, 8'h16, 8'h79, 8'h16, 8'h1E, 8'h26, 8'h55,
                                 8'h69, 8'h72, 8'h7B, 8'h7A, 8'h6B, 8'h5A,
                                 8'h79, 8'h46, 8'h46, 8'h46, 8'h46, 8'h55,
                                 8'h76, 8'h16};

    initial begin
        int r, d;
        stim.key_vld  = 1'b0;
        stim.key_code = 8'h00;
        msub = 0; mbrk = 0;
        model_clear();
        repeat (4) @(negedge clk);
        chk("rst_an", 32'(an), 32'hFE);
        chk("rst_seg", 32'(seg), 32'hC0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_an", 32'(an), 32'hFE);
        chk("post_rst_seg", 32'(seg), 32'hC0);
        check_disp("reset");

        foreach (dir_keys[i]) key(dir_keys[i]);
        // A=1 here: corrupted frames and a released key must leave it alone.
        ps2_frame(8'h46, 1'b1, 1'b0, 1'b0); check_disp("bad_start");
        ps2_frame(8'h46, 1'b0, 1'b1, 1'b0); check_disp("bad_stop");
        key(8'hF0); key(8'h46);
        key(8'hE0);
        foreach (dcode[i]) if (i >= 2 && i <= 5) key(dcode[i]);
        ps2_frame(8'h3E, 1'b0, 1'b0, 1'b1);
`ifndef PS2_PARITY_CHECK_EN
        model_key(8'h3E);
`endif
        check_disp("bad_par");
        key(8'h76);
        ps2_frame(8'h1E, 1'b0, 1'b0, 1'b1);
`ifndef PS2_PARITY_CHECK_EN
        model_key(8'h1E);
`endif
        check_disp("bad_par2");

        for (int n = 0; n < 130; n++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 9);
            if (r < 50)      key(($urandom_range(0, 1) != 0) ? kcode[d] : dcode[d]);
            else if (r < 62) key(8'h79);
            else if (r < 72) key(8'h7B);
            else if (r < 80) key(($urandom_range(0, 1) != 0) ? 8'h55 : 8'h5A);
            else if (r < 84) key(8'h76);
            else if (r < 90) begin key(8'hF0); key(dcode[d]); end
            else if (r < 94) key(8'hE0);
            else             key(junk[d % 5]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
